alu_op_sequencer: RTL and testbench

- Initiator side of the 64-bit ALU interface: accepts accumulator-style commands over a valid/ready channel.
- Drives the ALU's funct/a/b, captures its result and status flags, and repeats an op N times.
- Returns a response over a second valid/ready channel; the ALU itself stays external, combinational, same-cycle.
- Sits between the control unit and the ALU datapath.

---
 rtl/alu_seq_pkg.sv | 38 +++
 rtl/alu_op_sequencer.sv | 156 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU operation sequencer.
//   - op_e      : 3-bit ALU opcode (LOAD..INC, 7 reserved)
//   - FLAG_*    : bit positions inside the 6-bit ALU flag vector
//   - state_e   : sequencer FSM states
//   - op_is_arith: true for opcodes whose overflow flag is meaningful
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_SUM  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_XOR  = 3'd4,
    OP_NOT  = 3'd5,
    OP_INC  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  localparam int FLAG_OVF  = 5;
  localparam int FLAG_NEG  = 4;
  localparam int FLAG_ZERO = 3;
  localparam int FLAG_EQ   = 2;
  localparam int FLAG_GT   = 1;
  localparam int FLAG_LT   = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // The ALU reports an overflow bit for every op; it only means something
  // for add and subtract.
  function automatic logic op_is_arith(op_e op);
    return (op == OP_SUM) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator side of an external combinational ALU.
// Accepts accumulator-style commands on a valid/ready channel, drives the
// ALU funct/a/b for N steps (one per cycle), folds each result into the
// accumulator and returns the final value and flags on a response channel.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op/cmd_operand/cmd_use_acc/cmd_rep  command fields
//   rsp_valid/rsp_ready           response handshake
//   rsp_result/rsp_flags/rsp_ovf_any        response payload
//   acc_q                         current accumulator
//   alu_funct/alu_a/alu_b         to the ALU
//   alu_result/alu_flags          from the ALU (same cycle)
//   ovf_sticky/ovf_clr            only when ALU_SEQ_STICKY_OVF_EN is defined
//
// Build option: define ALU_SEQ_STICKY_OVF_EN to add a sticky overflow flag
// that persists across commands until ovf_clr or reset.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  input  logic             cmd_use_acc,
  input  logic [REP_W-1:0] cmd_rep,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [5:0]       rsp_flags,
  output logic             rsp_ovf_any,
  output logic [WIDTH-1:0] acc_q,
`ifdef ALU_SEQ_STICKY_OVF_EN
  output logic             ovf_sticky,
  input  logic             ovf_clr,
`endif
  output logic [2:0]       alu_funct,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [5:0]       alu_flags
);

  state_e           r_state, w_state_nxt;
  op_e              r_op;
  logic [WIDTH-1:0] r_operand;
  logic [WIDTH-1:0] r_acc;
  logic             r_use_acc;
  logic             r_first;
  logic [REP_W-1:0] r_cnt;
  logic [5:0]       r_flags;
  logic             r_ovf_any;

  logic             w_accept;
  logic             w_step;
  logic             w_ovf_step;
  logic [WIDTH-1:0] w_step_res;

  assign w_accept   = cmd_valid && cmd_ready;
  assign w_step     = (r_state == S_EXEC);
  assign w_ovf_step = w_step && alu_flags[FLAG_OVF] && op_is_arith(r_op);
  // Reserved op runs as LOAD; take a directly so the result never depends
  // on how the ALU treats an unused funct code.
  assign w_step_res = (r_op == OP_RSVD) ? alu_a : alu_result;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    alu_funct   = OP_LOAD;
    alu_a       = r_acc;
    alu_b       = '0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        alu_funct = (r_op == OP_RSVD) ? OP_LOAD : r_op;
        alu_b     = r_operand;
        if (r_first && !r_use_acc) alu_a = r_operand;
        if (r_cnt == REP_W'(1)) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= OP_LOAD;
      r_operand <= '0;
      r_acc     <= '0;
      r_use_acc <= 1'b0;
      r_first   <= 1'b0;
      r_cnt     <= '0;
      r_flags   <= '0;
      r_ovf_any <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op      <= op_e'(cmd_op);
        r_operand <= cmd_operand;
        r_use_acc <= cmd_use_acc;
        r_first   <= 1'b1;
        r_cnt     <= (cmd_rep == '0) ? REP_W'(1) : cmd_rep;
        r_ovf_any <= 1'b0;
      end
      if (w_step) begin
        r_acc     <= w_step_res;
        r_flags   <= {w_ovf_step, alu_flags[FLAG_OVF-1:0]};
        r_ovf_any <= r_ovf_any | w_ovf_step;
        r_cnt     <= r_cnt - REP_W'(1);
        r_first   <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_STICKY_OVF_EN
  logic r_ovf_sticky;

  // A new overflow in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_ovf_sticky <= 1'b0;
    else if (w_ovf_step) r_ovf_sticky <= 1'b1;
    else if (ovf_clr)    r_ovf_sticky <= 1'b0;
  end

  assign ovf_sticky = r_ovf_sticky;
`endif

  // Accumulator only moves in EXEC, so the response payload is stable
  // for the whole RESP phase without a separate capture register.
  assign rsp_result  = r_acc;
  assign rsp_flags   = r_flags;
  assign rsp_ovf_any = r_ovf_any;
  assign acc_q       = r_acc;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: self-checking bench for alu_op_sequencer.
// Contains a behavioural ALU wired to the DUT and a command-level reference
// model that computes each command's outcome as a plain loop over steps.
module tb_alu_op_sequencer;

  localparam int WIDTH = 64;
  localparam int REP_W = 4;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_operand;
  logic             cmd_use_acc;
  logic [REP_W-1:0] cmd_rep;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [5:0]       rsp_flags;
  logic             rsp_ovf_any;
  logic [WIDTH-1:0] acc_q;
  logic [2:0]       alu_funct;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic [5:0]       alu_flags;
`ifdef ALU_SEQ_STICKY_OVF_EN
  logic             ovf_sticky;
  logic             ovf_clr;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] m_acc;
  logic             m_sticky;

  alu_op_sequencer #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_operand (cmd_operand),
    .cmd_use_acc (cmd_use_acc),
    .cmd_rep     (cmd_rep),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags),
    .rsp_ovf_any (rsp_ovf_any),
    .acc_q       (acc_q),
`ifdef ALU_SEQ_STICKY_OVF_EN
    .ovf_sticky  (ovf_sticky),
    .ovf_clr     (ovf_clr),
`endif
    .alu_funct   (alu_funct),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: {flags[5:0], result[63:0]}. For non-arithmetic ops the
  // overflow bit is deliberately junk (a[0]) so masking is exercised.
  function automatic logic [69:0] alu_eval(logic [2:0] f, logic [63:0] a, logic [63:0] b);
    logic [63:0] r;
    logic        ovf;
    case (f)
      3'd0:    r = a;
      3'd1:    r = a + b;
      3'd2:    r = a - b;
      3'd3:    r = a & b;
      3'd4:    r = a ^ b;
      3'd5:    r = ~a;
      3'd6:    r = a + 64'd1;
      default: r = a ^ b;
    endcase
    case (f)
      3'd1:    ovf = (a[63] == b[63]) && (r[63] != a[63]);
      3'd2:    ovf = (a[63] != b[63]) && (r[63] != a[63]);
      default: ovf = a[0];
    endcase
    return {ovf, r[63], (r == 64'd0), (a == b), ($signed(a) > $signed(b)),
            ($signed(a) < $signed(b)), r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_eval(alu_funct, alu_a, alu_b);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one command from a negedge, stall the response `stall` cycles,
  // and compare everything against the command-level model.
  task automatic run_cmd(input logic [2:0] op, input logic [63:0] opnd, input logic use_acc,
                         input logic [3:0] rep, input int stall);
    int          n;
    int          lat;
    logic [63:0] a;
    logic [69:0] v;
    logic [5:0]  e_flags;
    logic        e_ovf;
    logic [2:0]  fop;

    n       = (rep == 4'd0) ? 1 : int'(rep);
    fop     = (op == 3'd7) ? 3'd0 : op;
    e_ovf   = 1'b0;
    e_flags = '0;
    for (int i = 0; i < n; i++) begin
      a = (i == 0 && !use_acc) ? opnd : m_acc;
      v = alu_eval(fop, a, opnd);
      if (!(op == 3'd1 || op == 3'd2)) v[69] = 1'b0;
      e_ovf   = e_ovf | v[69];
      m_acc   = v[63:0];
      e_flags = v[69:64];
    end
    m_sticky = m_sticky | e_ovf;

    check("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_operand = opnd;
    cmd_use_acc = use_acc;
    cmd_rep     = rep;
    @(posedge clk);
    #1 cmd_valid = 1'b0;

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 40);
    check("latency", 64'(lat), 64'(n + 1));

    for (int s = 0; s < stall; s++) begin
      check("stall_valid", {63'd0, rsp_valid}, 64'd1);
      check("stall_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      check("stall_result", rsp_result, m_acc);
      check("stall_flags", {58'd0, rsp_flags}, {58'd0, e_flags});
      if (s == 0) begin
        cmd_valid = 1'b1;
        cmd_op    = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;

    check("rsp_result", rsp_result, m_acc);
    check("rsp_flags", {58'd0, rsp_flags}, {58'd0, e_flags});
    check("rsp_ovf_any", {63'd0, rsp_ovf_any}, {63'd0, e_ovf});
    check("acc_q", acc_q, m_acc);
`ifdef ALU_SEQ_STICKY_OVF_EN
    check("ovf_sticky", {63'd0, ovf_sticky}, {63'd0, m_sticky});
`endif
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_valid_drop", {63'd0, rsp_valid}, 64'd0);
    check("cmd_ready_back", {63'd0, cmd_ready}, 64'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_operand = '0;
    cmd_use_acc = 1'b0;
    cmd_rep     = '0;
    rsp_ready   = 1'b0;
`ifdef ALU_SEQ_STICKY_OVF_EN
    ovf_clr     = 1'b0;
`endif
    m_acc       = '0;
    m_sticky    = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_acc", acc_q, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_result", rsp_result, 64'd0);
    check("rst_rsp_flags", {58'd0, rsp_flags}, 64'd0);
    check("rst_ovf_any", {63'd0, rsp_ovf_any}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("idle_alu_funct", {61'd0, alu_funct}, 64'd0);
    check("idle_alu_b", alu_b, 64'd0);

    // Directed scenarios with hand-derived constants alongside the model.
    run_cmd(3'd0, 64'd5, 1'b0, 4'd1, 0);
    check("tp_load5", acc_q, 64'd5);
    check("tp_load5_zero", {63'd0, rsp_flags[3]}, 64'd0);
    run_cmd(3'd1, 64'd3, 1'b1, 4'd4, 0);
    check("tp_sum17", rsp_result, 64'd17);
    check("tp_sum17_ovf", {63'd0, rsp_ovf_any}, 64'd0);
    run_cmd(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 4'd1, 0);
    run_cmd(3'd1, 64'd1, 1'b1, 4'd1, 0);
    check("tp_ovf_result", rsp_result, 64'h8000_0000_0000_0000);
    check("tp_ovf_neg", {62'd0, rsp_flags[5:4]}, 64'd3);
    check("tp_ovf_any", {63'd0, rsp_ovf_any}, 64'd1);
    run_cmd(3'd0, 64'd17, 1'b0, 4'd1, 0);
    run_cmd(3'd2, 64'd17, 1'b1, 4'd0, 5);
    check("tp_sub_zero", rsp_result, 64'd0);
    check("tp_sub_flags", {60'd0, rsp_flags[3:0]}, 64'hC);

    // Randomized commands, including the reserved opcode and stalls.
    for (int k = 0; k < 30; k++) begin
      run_cmd(3'($urandom_range(0, 7)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 6)), $urandom_range(0, 3));
    end
    run_cmd(3'd7, 64'hDEAD_BEEF_0000_0001, 1'b0, 4'd3, 1);
    check("rsvd_load", acc_q, 64'hDEAD_BEEF_0000_0001);

    // Reset in the middle of a long INC command.
    cmd_valid   = 1'b1;
    cmd_op      = 3'd6;
    cmd_operand = 64'd0;
    cmd_use_acc = 1'b1;
    cmd_rep     = 4'd8;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_acc", acc_q, 64'd0);
    check("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    m_acc    = '0;
    m_sticky = 1'b0;
    @(negedge clk);
    check("midrst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("midrst_rsp_valid2", {63'd0, rsp_valid}, 64'd0);
    run_cmd(3'd6, 64'd0, 1'b1, 4'd2, 0);
    check("post_rst_inc", acc_q, 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
